stopwatch_display: RTL and testbench
====================================

// Module: stopwatch_display
// PURPOSE
//  Reader side of the stopwatch BCD digit bus: takes sec1/sec0/ms1/ms0 and drives a
//  4-digit multiplexed common-anode 7-segment display. Provides frame-coherent sampling
//  (no digit tearing), lap hold, leading-zero blanking and invalid-BCD flagging.
//  Sits between the stopwatch counter and the board display pins.
// PARAMETERS
//  SCAN_DIV        50000  clk cycles per digit slot; must be >= 2
//  BLANK_LEAD      1      1 = blank digit 3 when its shadow value is 0
//  SEG_ACTIVE_LOW  1      1 = an, seg and dp are active-low; 0 = active-high
// PORTS
//  clk        in   1  system clock; all logic on the rising edge
//  rst_n      in   1  asynchronous, active-low reset
//  sec1       in   4  BCD tens of seconds from the stopwatch
//  sec0       in   4  BCD units of seconds
//  ms1        in   4  BCD tenths
//  ms0        in   4  BCD hundredths
//  hold       in   1  level; 1 = freeze the displayed value (lap)
//  an         out  4  digit enables; an[0] = rightmost digit (ms0)
//  seg        out  7  segments {g,f,e,d,c,b,a}
//  dp         out  1  decimal point
//  digit_err  out  1  sticky; set when a displayed digit held a value > 9
// BEHAVIOUR
//  - Reset (async assert): prescaler=0, index=0, shadow regs=0, load_pending=1,
//    digit_err=0; an, seg and dp all driven inactive (0xF/0x7F/1 when active-low).
//  - Prescaler counts 0..SCAN_DIV-1 and wraps; tick = (count==SCAN_DIV-1).
//    The index advances 0->1->2->3->0 on each tick.
//  - Slot mapping: index 0=ms0, 1=ms1, 2=sec0, 3=sec1.
//  - Shadow load: all four inputs are captured together into the shadow regs when
//    (tick && index==3 && !hold) || load_pending. load_pending clears after its load,
//    so the first load is on the first clk edge after reset release.
//  - hold=1: shadow is never reloaded, even if a frame boundary is reached. Release:
//    reload at the next frame boundary. hold does not affect scanning.
//  - Outputs are registered and are a function of the index and shadow. They reflect a
//    new index 1 cycle after the tick, and new shadow data 1 cycle after the load.
//  - Active-high seg codes: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F.
//    A value > 9 shows a dash (40) and sets digit_err when that slot is driven;
//    digit_err stays set until reset.
//  - dp is asserted only in slot 2 (display reads SS.mm).
//  - Blanking: if BLANK_LEAD and shadow sec1==0, an stays inactive during slot 3;
//    the prescaler still runs, so slot timing is unchanged.
//  - When SEG_ACTIVE_LOW=1, an, seg and dp are inverted at the output register.
//  - Reset asserted mid-scan: outputs go inactive immediately; after release the scan
//    restarts at slot 0.
// TESTING (SCAN_DIV=4, SEG_ACTIVE_LOW=1, BLANK_LEAD=1)
//  1 rst_n=0 -> an=4'hF, seg=7'h7F, dp=1, digit_err=0; release -> an=4'hE by 2nd edge.
//  2 inputs 1,2,3,4 (sec1..ms0) -> each slot lasts 4 cycles in sequence:
//    an=E/seg=19, an=D/seg=30, an=B/seg=24/dp=0, an=7/seg=79.
//  3 sec1=0, sec0=5 -> an stays F for slot 3; slot 2 shows seg=12 with dp=0.
//  4 hold=1, then inputs change for 3 frames -> an/seg sequence unchanged; hold=0 ->
//    new digits appear from the slot 0 following the next frame boundary.
//  5 ms0=4'hC -> slot 0 seg=3F (dash) and digit_err=1; ms0=4'h3 -> seg=30, digit_err stays 1.
//  6 rst_n pulsed low during slot 2 -> outputs inactive in the same cycle; after
//    release, the scan restarts at an=E and shadow is reloaded.

Source files
------------

// File: rtl/stopwatch_display.sv
// Multiplexed 4-digit common-anode 7-segment driver for the stopwatch BCD bus.
// Frame-coherent shadow capture, lap hold, leading-zero blanking, sticky invalid-digit flag.
module stopwatch_display #(
  parameter int SCAN_DIV       = 50000,
  parameter bit BLANK_LEAD     = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sec1,
  input  logic [3:0] sec0,
  input  logic [3:0] ms1,
  input  logic [3:0] ms0,
  input  logic       hold,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       digit_err
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  // Inactive levels depend on the output polarity.
  localparam logic [3:0] AN_OFF  = SEG_ACTIVE_LOW ? 4'hF  : 4'h0;
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = SEG_ACTIVE_LOW ? 1'b1  : 1'b0;

  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [3:0][3:0] sh_q, sh_d;
  logic            load_pending_q, load_pending_d;
  logic [3:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;
  logic            err_q, err_d;

  logic            tick, load;
  logic [3:0]      digit;
  logic            blank, bad;
  logic [3:0]      an_raw;
  logic [6:0]      seg_raw;
  logic            dp_raw;

  function automatic logic [6:0] bcd2seg(input logic [3:0] v);
    case (v)
      4'd0:    bcd2seg = 7'h3F;
      4'd1:    bcd2seg = 7'h06;
      4'd2:    bcd2seg = 7'h5B;
      4'd3:    bcd2seg = 7'h4F;
      4'd4:    bcd2seg = 7'h66;
      4'd5:    bcd2seg = 7'h6D;
      4'd6:    bcd2seg = 7'h7D;
      4'd7:    bcd2seg = 7'h07;
      4'd8:    bcd2seg = 7'h7F;
      4'd9:    bcd2seg = 7'h6F;
      default: bcd2seg = 7'h40;
    endcase
  endfunction

  assign tick = (cnt_q == CW'(SCAN_DIV - 1));
  // Capture all four digits at once so a frame never mixes old and new values.
  assign load = (tick && (idx_q == 2'd3) && !hold) || load_pending_q;

  always_comb begin
    cnt_d          = tick ? '0 : cnt_q + 1'b1;
    idx_d          = tick ? idx_q + 2'd1 : idx_q;
    sh_d           = load ? {sec1, sec0, ms1, ms0} : sh_q;
    load_pending_d = 1'b0;
  end

  // Output path uses the current slot and shadow; registered one cycle later.
  always_comb begin
    digit   = sh_q[idx_q];
    blank   = BLANK_LEAD && (idx_q == 2'd3) && (sh_q[3] == 4'd0);
    bad     = !blank && (digit > 4'd9);
    an_raw  = blank ? 4'h0 : (4'b0001 << idx_q);
    seg_raw = blank ? 7'h00 : bcd2seg(digit);
    dp_raw  = (idx_q == 2'd2);
    an_d    = SEG_ACTIVE_LOW ? ~an_raw  : an_raw;
    seg_d   = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
    dp_d    = SEG_ACTIVE_LOW ? ~dp_raw  : dp_raw;
    err_d   = err_q | bad;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q          <= '0;
      idx_q          <= 2'd0;
      sh_q           <= '0;
      load_pending_q <= 1'b1;
      an_q           <= AN_OFF;
      seg_q          <= SEG_OFF;
      dp_q           <= DP_OFF;
      err_q          <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      sh_q           <= sh_d;
      load_pending_q <= load_pending_d;
      an_q           <= an_d;
      seg_q          <= seg_d;
      dp_q           <= dp_d;
      err_q          <= err_d;
    end
  end

  assign an        = an_q;
  assign seg       = seg_q;
  assign dp        = dp_q;
  assign digit_err = err_q;

endmodule

// File: tb/tb_stopwatch_display.sv
// Bench for stopwatch_display: directed steps plus random digits/hold against a
// cycle-count based reference model of the scan and frame-load rules.
module tb_stopwatch_display;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sec1 = 4'd0, sec0 = 4'd0, ms1 = 4'd0, ms0 = 4'd0;
  logic       hold = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       digit_err;

  stopwatch_display #(.SCAN_DIV(D), .BLANK_LEAD(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .sec1(sec1), .sec0(sec0), .ms1(ms1), .ms0(ms0),
    .hold(hold), .an(an), .seg(seg), .dp(dp), .digit_err(digit_err)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference state: edges since reset release, shadow copy (0=ms0..3=sec1), sticky error.
  int         k = 0;
  logic [3:0] sh [4] = '{4'd0, 4'd0, 4'd0, 4'd0};
  logic       err_m = 1'b0;
  logic [6:0] segtab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                              7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
  endtask

  task automatic model_reset();
    k = 0;
    sh = '{4'd0, 4'd0, 4'd0, 4'd0};
    err_m = 1'b0;
  endtask

  // One clock edge: compare outputs with the model, then apply that edge's shadow load.
  task automatic step();
    int         slot;
    logic [3:0] v;
    logic       bl;
    logic [3:0] ea;
    logic [6:0] es;
    @(posedge clk); #1;
    k++;
    slot = ((k - 1) / D) % 4;
    v    = sh[slot];
    bl   = (slot == 3) && (sh[3] == 4'd0);
    ea   = bl ? 4'hF : (4'hF ^ 4'(1 << slot));
    es   = bl ? 7'h7F : ~((v > 4'd9) ? 7'h40 : segtab[v]);
    if (!bl && v > 4'd9) err_m = 1'b1;
    chk("an",  32'(an),  32'(ea));
    chk("seg", 32'(seg), 32'(es));
    chk("dp",  32'(dp),  32'(slot != 2));
    chk("err", 32'(digit_err), 32'(err_m));
    if (k == 1 || ((k % (4 * D)) == 0 && !hold))
      sh = '{ms0, ms1, sec0, sec1};
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_an",  32'(an),  32'h F);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp",  32'(dp),  32'h1);
    chk("rst_err", 32'(digit_err), 32'h0);

    // Digits 1,2,3,4 across several frames
    {sec1, sec0, ms1, ms0} = {4'd1, 4'd2, 4'd3, 4'd4};
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    run(2);
    chk("rel_an", 32'(an), 32'hE);
    run(4 * 4 * D);

    // Leading zero blanking with sec0=5
    {sec1, sec0} = {4'd0, 4'd5};
    run(3 * 4 * D);

    // Hold for 3 frames while inputs keep changing, then release
    hold = 1'b1;
    for (int i = 0; i < 3 * 4 * D; i++) begin
      {sec1, sec0, ms1, ms0} = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                                4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      step();
    end
    hold = 1'b0;
    run(3 * 4 * D);

    // Random valid digits with random hold
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0)
        {sec1, sec0, ms1, ms0} = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                                  4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      if ($urandom_range(0, 39) == 0) hold = ~hold;
      step();
    end
    hold = 1'b0;

    // Invalid digit flags and stays flagged
    {sec1, sec0, ms1, ms0} = {4'd1, 4'd2, 4'd3, 4'hC};
    run(3 * 4 * D);
    chk("err_set", 32'(digit_err), 32'h1);
    ms0 = 4'h3;
    run(3 * 4 * D);
    chk("err_sticky", 32'(digit_err), 32'h1);

    // Asynchronous reset during slot 2
    for (int i = 0; i < 8 * D; i++) begin
      if (((k) / D) % 4 == 2) break;
      step();
    end
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_an",  32'(an),  32'hF);
    chk("mid_seg", 32'(seg), 32'h7F);
    chk("mid_dp",  32'(dp),  32'h1);
    chk("mid_err", 32'(digit_err), 32'h0);
    {sec1, sec0, ms1, ms0} = {4'd5, 4'd9, 4'd0, 4'd7};
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    model_reset();
    run(2 * 4 * D);

    // Random digits including invalid values
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 5) == 0)
        {sec1, sec0, ms1, ms0} = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 9)),
                                  4'($urandom_range(0, 9)), 4'($urandom_range(0, 15))};
      if ($urandom_range(0, 29) == 0) hold = ~hold;
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
